// File: rtl/tree_noc_pkg.sv
// Shared width helpers for the tree routing blocks.
package tree_noc_pkg;

  // Ceiling log2. Values of 1 or less map to 1 so that every derived field
  // is at least one bit wide.
  function automatic int log2(input int n);
    if (n <= 1) return 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) >= n) return i;
    end
    return 31;
  endfunction

  // Bits to select one down-port.
  function automatic int kw_f(input int k);
    return log2(k);
  endfunction

  // Bits of an encoded destination address: one down-port select per level.
  function automatic int lkw_f(input int k, input int l);
    return l * log2(k);
  endfunction

  // Bits of an encoded destport: K down-ports plus the up-port (value K).
  function automatic int dspw_f(input int k);
    return log2(k + 1);
  endfunction

endpackage

// File: rtl/tree_route_fifo.sv
// One per-VC route queue: DEPTH entries, head presented combinationally
// from storage, zero when empty. Error strobes are single-cycle.
module tree_route_fifo
  import tree_noc_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] head_o,
  output logic [log2(DEPTH):0] count_o,
  output logic         full_o,
  output logic         ovf_o,
  output logic         udf_o
);

  localparam int DW = log2(DEPTH) + 1;
  localparam int PW = DW - 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] count_q, count_d;

  logic empty;
  logic full;
  logic do_push;
  logic do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == DW'(DEPTH));

  // Push is accepted unless full with no pop; a pop on an empty queue is ignored.
  always_comb begin
    do_push  = push_i && (!full || pop_i);
    do_pop   = pop_i && !empty;
    ovf_o    = push_i && full && !pop_i;
    udf_o    = pop_i && empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + DW'(do_push) - DW'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Queue state registers; reset also clears storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head entry, forced to zero when nothing is stored.
  always_comb begin
    head_o = '0;
    if (!empty) head_o = mem_q[rd_ptr_q];
  end

  assign count_o = count_q;
  assign full_o  = full;

endmodule

// File: rtl/tree_ivc_route_queue.sv
// Per-input-port route holding stage: captures header routes per VC and
// presents the oldest route of each VC until its tail leaves the crossbar.
module tree_ivc_route_queue
  import tree_noc_pkg::*;
#(
  parameter int V     = 4,
  parameter int K     = 2,
  parameter int L     = 2,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flit_wr_i,
  input  logic [V-1:0]              flit_vc_i,
  input  logic                      hdr_flg_i,
  input  logic [dspw_f(K)-1:0]      destport_i,
  input  logic [lkw_f(K,L)-1:0]     dest_addr_i,
  input  logic [V-1:0]              tail_sent_i,
  output logic [V-1:0]              route_valid_o,
  output logic [V*dspw_f(K)-1:0]    destport_o,
  output logic [V*lkw_f(K,L)-1:0]   dest_addr_o,
  output logic [V-1:0]              full_o,
  output logic [2:0]                err_o
);

  localparam int LKW  = lkw_f(K, L);
  localparam int DSPW = dspw_f(K);
  localparam int W    = DSPW + LKW;
  localparam int DW   = log2(DEPTH) + 1;

  logic [V-1:0]  push_v;
  logic [V-1:0]  ovf_v;
  logic [V-1:0]  udf_v;
  logic          hdr_push;
  logic          dp_err;
  logic [2:0]    err_q, err_d;

  // A header write pushes into the VC selected by the one-hot flit_vc_i.
  always_comb begin
    hdr_push = flit_wr_i && hdr_flg_i;
    push_v   = hdr_push ? flit_vc_i : '0;
    dp_err   = hdr_push && (|flit_vc_i) && (destport_i > DSPW'(K));
  end

  for (genvar v = 0; v < V; v++) begin : gen_vc
    logic [W-1:0]  head;
    logic [DW-1:0] count;

    tree_route_fifo #(
      .DEPTH (DEPTH),
      .W     (W)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push_v[v]),
      .pop_i   (tail_sent_i[v]),
      .data_i  ({destport_i, dest_addr_i}),
      .head_o  (head),
      .count_o (count),
      .full_o  (full_o[v]),
      .ovf_o   (ovf_v[v]),
      .udf_o   (udf_v[v])
    );

    assign route_valid_o[v]             = (count != '0);
    assign destport_o[v*DSPW +: DSPW]   = head[W-1 -: DSPW];
    assign dest_addr_o[v*LKW +: LKW]    = head[LKW-1:0];
  end

  // Sticky error accumulation across all VCs.
  always_comb begin
    err_d = err_q | {dp_err, |udf_v, |ovf_v};
  end

  // Error register, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= '0;
    else        err_q <= err_d;
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_tree_ivc_route_queue.sv
// Randomised and directed bench for tree_ivc_route_queue against a queue model.
module tb_tree_ivc_route_queue;

  localparam int V     = 4;
  localparam int K     = 2;
  localparam int L     = 2;
  localparam int DEPTH = 2;
  localparam int LKW   = 2;
  localparam int DSPW  = 2;
  localparam int W     = DSPW + LKW;

  logic              clk;
  logic              rst_n;
  logic              flit_wr;
  logic [V-1:0]      flit_vc;
  logic              hdr_flg;
  logic [DSPW-1:0]   destport;
  logic [LKW-1:0]    dest_addr;
  logic [V-1:0]      tail_sent;
  logic [V-1:0]      route_valid;
  logic [V*DSPW-1:0] destport_o;
  logic [V*LKW-1:0]  dest_addr_o;
  logic [V-1:0]      full;
  logic [2:0]        err;

  int n_vec;
  int n_bad;

  logic [W-1:0] mq [V][$];
  logic [2:0]   m_err;

  tree_ivc_route_queue #(.V(V), .K(K), .L(L), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (rst_n),
    .flit_wr_i     (flit_wr),
    .flit_vc_i     (flit_vc),
    .hdr_flg_i     (hdr_flg),
    .destport_i    (destport),
    .dest_addr_i   (dest_addr),
    .tail_sent_i   (tail_sent),
    .route_valid_o (route_valid),
    .destport_o    (destport_o),
    .dest_addr_o   (dest_addr_o),
    .full_o        (full),
    .err_o         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int v = 0; v < V; v++) mq[v].delete();
    m_err = '0;
  endtask

  // Apply the queue rules to the inputs sampled at this edge.
  task automatic model_edge();
    for (int v = 0; v < V; v++) begin
      bit ps, pp;
      int n;
      ps = flit_wr && hdr_flg && flit_vc[v];
      pp = tail_sent[v];
      n  = mq[v].size();
      if (ps && pp) begin
        if (n == 0) m_err[1] = 1'b1;
        else        mq[v].delete(0);
        mq[v].push_back({destport, dest_addr});
      end else if (ps) begin
        if (n == DEPTH) m_err[0] = 1'b1;
        else            mq[v].push_back({destport, dest_addr});
      end else if (pp) begin
        if (n == 0) m_err[1] = 1'b1;
        else        mq[v].delete(0);
      end
    end
    if (flit_wr && hdr_flg && (flit_vc != 0) && (int'(destport) > K)) m_err[2] = 1'b1;
  endtask

  task automatic model_compare();
    logic [V-1:0]      e_valid, e_full;
    logic [V*DSPW-1:0] e_dp;
    logic [V*LKW-1:0]  e_ad;
    e_valid = '0; e_full = '0; e_dp = '0; e_ad = '0;
    for (int v = 0; v < V; v++) begin
      if (mq[v].size() != 0) begin
        logic [W-1:0] h;
        h = mq[v][0];
        e_valid[v] = 1'b1;
        e_dp[v*DSPW +: DSPW] = h[W-1 -: DSPW];
        e_ad[v*LKW +: LKW]   = h[LKW-1:0];
      end
      if (mq[v].size() == DEPTH) e_full[v] = 1'b1;
    end
    chk("route_valid", 32'(route_valid), 32'(e_valid));
    chk("destport",    32'(destport_o),  32'(e_dp));
    chk("dest_addr",   32'(dest_addr_o), 32'(e_ad));
    chk("full",        32'(full),        32'(e_full));
    chk("err",         32'(err),         32'(m_err));
  endtask

  // Called at a negedge: drive, take one posedge, then compare at the next negedge.
  task automatic step(input logic wr, input logic [V-1:0] vc, input logic hd,
                      input logic [DSPW-1:0] dp, input logic [LKW-1:0] ad,
                      input logic [V-1:0] tl);
    flit_wr = wr; flit_vc = vc; hdr_flg = hd;
    destport = dp; dest_addr = ad; tail_sent = tl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_compare();
  endtask

  task automatic hdr(input int v, input int dp, input int ad, input logic [V-1:0] tl);
    logic [V-1:0] oh;
    oh = '0;
    oh[v] = 1'b1;
    step(1'b1, oh, 1'b1, DSPW'(dp), LKW'(ad), tl);
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear at once.
  task automatic async_reset();
    flit_wr = 0; flit_vc = 0; hdr_flg = 0; destport = 0; dest_addr = 0; tail_sent = 0;
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("rst_valid", 32'(route_valid), 32'h0);
    chk("rst_dp",    32'(destport_o),  32'h0);
    chk("rst_addr",  32'(dest_addr_o), 32'h0);
    chk("rst_full",  32'(full),        32'h0);
    chk("rst_err",   32'(err),         32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_compare();
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    rst_n = 1'b0;
    flit_wr = 0; flit_vc = 0; hdr_flg = 0; destport = 0; dest_addr = 0; tail_sent = 0;
    model_clear();
    repeat (3) @(negedge clk);
    model_compare();
    rst_n = 1'b1;

    // Header on VC1, then its tail.
    hdr(1, 1, 2, 4'b0000);
    chk("t1_valid", 32'(route_valid), 32'h2);
    chk("t1_dp",    32'(destport_o[3:2]), 32'h1);
    chk("t1_addr",  32'(dest_addr_o[3:2]), 32'h2);
    step(0, 0, 0, 0, 0, 4'b0010);
    chk("t1_pop", 32'(route_valid), 32'h0);

    // Two headers on VC0, popped one at a time.
    hdr(0, 0, 1, 4'b0000);
    hdr(0, 2, 3, 4'b0000);
    chk("t2_full", 32'(full[0]), 32'h1);
    chk("t2_dp0",  32'(destport_o[1:0]), 32'h0);
    step(0, 0, 0, 0, 0, 4'b0001);
    chk("t2_dp1",  32'(destport_o[1:0]), 32'h2);
    step(0, 0, 0, 0, 0, 4'b0001);
    chk("t2_empty", 32'(route_valid[0]), 32'h0);
    chk("t2_dpz",   32'(destport_o[1:0]), 32'h0);

    // VC2 full, then push and pop together.
    hdr(2, 1, 0, 4'b0000);
    hdr(2, 0, 1, 4'b0000);
    hdr(2, 2, 2, 4'b0100);
    chk("t3_full", 32'(full[2]), 32'h1);
    chk("t3_err",  32'(err), 32'h0);
    chk("t3_dp",   32'(destport_o[5:4]), 32'h0);
    step(0, 0, 0, 0, 0, 4'b0100);
    chk("t3_new",  32'(destport_o[5:4]), 32'h2);
    chk("t3_addr", 32'(dest_addr_o[5:4]), 32'h2);
    step(0, 0, 0, 0, 0, 4'b0100);

    // Overflow on VC3, then underflow on empty VC1.
    hdr(3, 1, 1, 4'b0000);
    hdr(3, 2, 0, 4'b0000);
    hdr(3, 0, 3, 4'b0000);
    chk("t4_ovf",  32'(err), 32'h1);
    chk("t4_head", 32'(destport_o[7:6]), 32'h1);
    step(0, 0, 0, 0, 0, 4'b0010);
    chk("t4_udf",  32'(err), 32'h3);

    // Out-of-range destport is still stored.
    hdr(1, 3, 1, 4'b0000);
    chk("t5_dp",  32'(destport_o[3:2]), 32'h3);
    chk("t5_err", 32'(err), 32'h7);

    // Fill the remaining VCs and reset mid-cycle.
    hdr(0, 2, 2, 4'b0000);
    hdr(2, 1, 3, 4'b0000);
    chk("t6_valid", 32'(route_valid), 32'hF);
    async_reset();

    // Randomised traffic with periodic asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      logic [V-1:0] vc, tl;
      vc = ($urandom_range(15) == 0) ? 4'b0000 : V'(1 << $urandom_range(V-1));
      tl = '0;
      for (int v = 0; v < V; v++) tl[v] = ($urandom_range(3) == 0);
      step($urandom_range(3) != 0, vc, $urandom_range(1) == 1,
           ($urandom_range(7) == 0) ? DSPW'(3) : DSPW'($urandom_range(2)),
           LKW'($urandom_range(3)), tl);
      if ((i % 250) == 249) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tree_ivc_route_queue.md
# tree_ivc_route_queue

Per-input-port route holding stage for the tree/fat-tree router. It sits between the flit input write path and the tree destination-port generator. On every header flit it captures the look-ahead destination port and destination address into a small per-VC queue. It presents the oldest route of each VC until that packet's tail flit leaves the crossbar, so the downstream decoder/masker sees a stable encoded destport for the whole packet.

## Interface
- V, 4, number of virtual channels per input port (≥1)
- K, 2, down-ports per router; up-port encoding is K
- L, 2, tree height
- DEPTH, 2, route entries per VC (power of two, ≥2)
- Derived: Kw=log2(K), LKw=L·Kw, DSPw=log2(K+1), Dw=log2(DEPTH)+1 (log2 uses the codebase rule: log2(≤1)=1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset; one clock domain
- flit_wr_i  in  1  flit written into this input port this cycle
- flit_vc_i  in  V  one-hot VC of the written flit
- hdr_flg_i  in  1  written flit is a header
- destport_i  in  DSPw  encoded look-ahead destport carried in the header
- dest_addr_i  in  LKw  encoded destination address carried in the header
- tail_sent_i  in  V  one-hot pulse when a VC's tail flit leaves the crossbar
- route_valid_o  out  V  VC has a captured route
- destport_o  out  V·DSPw  oldest route destport per VC, VC0 in LSBs
- dest_addr_o  out  V·LKw  oldest route destination address per VC
- full_o  out  V  VC route queue holds DEPTH entries
- err_o  out  3  sticky errors: [0] push to a full queue, [1] pop from an empty queue, [2] destport > K

## Operation
- Push: when flit_wr_i=1, hdr_flg_i=1 and flit_vc_i[v]=1, write {destport_i, dest_addr_i} into queue v. Non-header flits never push. A header that is also a tail is treated as a header only; its pop comes later through tail_sent_i.
- Pop: when tail_sent_i[v]=1, discard the oldest entry of queue v. Pops on several VCs in the same cycle are independent.
- Per VC, the count takes values 0..DEPTH. Read and write pointers are Dw-1 bits and wrap modulo DEPTH.
- Push and pop on the same VC in the same cycle:
  - count unchanged; both operations take effect.
  - This holds even when the queue is full: the pop frees the slot the push uses.
  - If the queue is empty, the push is accepted, the pop is ignored, and err_o[1] is set.
- Push to a full queue without a simultaneous pop: the entry is dropped, state is unchanged, and err_o[0] is set.
- destport_i > K on a push: the entry is still stored and err_o[2] is set.
- route_valid_o[v] = (count≠0). destport_o and dest_addr_o show the entry at the read pointer, and are zero when the queue is empty.
- full_o[v] = (count==DEPTH).
- flit_vc_i that is not one-hot is a protocol violation; behaviour is undefined.
- err_o bits are sticky. Only reset clears them.

## Timing
- Reset (reset=0, asynchronous) clears:
  - all counts and pointers to 0
  - route_valid_o=0, full_o=0, destport_o=0, dest_addr_o=0, err_o=0
  - storage contents (set to 0)
- Reset deassertion is synchronous to clk through the existing codebase reset convention. A mid-packet reset drops every stored route.
- Push latency: 1 cycle. A header written at edge n gives route_valid_o=1 and a valid destport_o after edge n+1.
- Pop latency: 1 cycle. The next entry, or valid=0, appears after the edge that samples tail_sent_i.
- All outputs are driven from registers or register-to-mux paths. There is no combinational path from any input to any output.

## Structure
- Package tree_noc_pkg holds the log2 function and the Kw/LKw/DSPw derivations shared with the tree routing blocks.
- One sub-module, tree_route_fifo, is instantiated V times. It implements one DEPTH-entry queue with push, pop, count, full, empty, head data and per-queue error strobes.
- The top-level block does VC demux, output packing and the sticky error OR-reduction.

## Test plan
- Reset, then a header on VC1 with destport=1 and addr=0b10 → after 1 cycle route_valid_o=4'b0010 and destport_o[VC1]=1. A tail_sent_i=4'b0010 pulse → route_valid_o[1]=0 the next cycle.
- Two headers on VC0 (destport 0, then 2) → full_o[0]=1 and destport_o[VC0]=0. After one pop, destport_o=2. After a second pop, valid=0 and destport_o=0.
- VC2 full, then push and pop in the same cycle → count stays 2, no error, and the new entry appears after the next pop.
- Push to full VC3 without a pop → err_o=3'b001, queue contents unchanged. tail_sent_i on an empty VC → err_o[1]=1.
- Header with destport=3 (K=2) → entry stored, err_o[2]=1.
- Assert reset asynchronously mid-cycle with all VCs holding routes → every output is 0 immediately, with no clock edge required.
